uart_transceiver: RTL and testbench
===================================

UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 217, giving clock cycles per serial bit (25 MHz / 115200 baud).
REQ-002 The block SHALL have port i_Clock, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-003 The block SHALL have port i_Reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port i_TX_DV, input, 1 bit: a one-cycle request to transmit i_TX_Byte.
REQ-005 The block SHALL have port i_TX_Byte, input, 8 bits: the byte to transmit.
REQ-006 The block SHALL have port o_TX_Active, output, 1 bit: high while a frame is on the line.
REQ-007 The block SHALL have port o_TX_Serial, output, 1 bit: the serial transmit line; idle level is 1.
REQ-008 The block SHALL have port o_TX_Done, output, 1 bit: a one-cycle pulse at the end of each frame.
REQ-009 The block SHALL have port i_RX_Serial, input, 1 bit: the serial receive line, asynchronous to i_Clock.
REQ-010 The block SHALL have port o_RX_DV, output, 1 bit: a one-cycle pulse when a valid byte has been received.
REQ-011 The block SHALL have port o_RX_Byte, output, 8 bits: the last valid received byte.

Function
REQ-012 The frame format SHALL be 8N1: start bit 0, 8 data bits sent LSB first, stop bit 1, no parity; each bit lasts exactly CLKS_PER_BIT clocks.
REQ-013 TX states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-014 In IDLE, a cycle with i_TX_DV=1 SHALL latch i_TX_Byte; START begins on the next clock, with o_TX_Active=1 and o_TX_Serial=0.
REQ-015 TX SHALL shift data bits 0..7 in DATA, then drive 1 in STOP.
REQ-016 At the end of the stop bit, TX SHALL pulse o_TX_Done for exactly one cycle (DONE), clear o_TX_Active in the same cycle, and return to IDLE.
REQ-017 i_TX_DV SHALL be ignored in every TX state other than IDLE, and the latched byte SHALL be unaffected by i_TX_Byte changes mid-frame.
REQ-018 o_TX_Serial SHALL be 1 whenever TX is not in START or DATA.
REQ-019 i_RX_Serial SHALL pass through a 2-flop synchronizer before any use.
REQ-020 RX states SHALL be IDLE, START, DATA, STOP, CLEANUP.
REQ-021 In IDLE, a synchronized 0 SHALL enter START.
REQ-022 In START, after (CLKS_PER_BIT-1)/2 clocks, a sample of 0 SHALL enter DATA; a sample of 1 is a glitch and SHALL return to IDLE with no output change.
REQ-023 In DATA, RX SHALL sample every CLKS_PER_BIT clocks from the start-bit midpoint and store bit n into o_RX_Byte[n] (shift register internal), for n = 0..7.
REQ-024 In STOP, RX SHALL sample at mid-bit. If the sample is 1, the shift register SHALL be copied to o_RX_Byte and o_RX_DV pulsed for one cycle (CLEANUP). If the sample is 0 (framing error), there SHALL be no pulse and o_RX_Byte SHALL be unchanged.
REQ-025 RX SHALL return to IDLE right after CLEANUP or a framing error, so back-to-back frames with zero idle gap are received.
REQ-026 o_RX_Byte SHALL hold its value until the next valid frame.
REQ-027 RX and TX SHALL be fully independent, so simultaneous transmit and receive are allowed; external loopback of o_TX_Serial to i_RX_Serial SHALL reproduce every transmitted byte.
REQ-028 Bit and sample counters SHALL be wide enough for CLKS_PER_BIT-1, i.e. $clog2(CLKS_PER_BIT) bits.

Reset
REQ-029 While i_Reset=1, both state machines SHALL be in IDLE.
REQ-030 While i_Reset=1, counters SHALL be 0, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_RX_DV=0, o_RX_Byte=8'h00, and the synchronizer flops SHALL be 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately with no o_TX_Done or o_RX_DV pulse.

Structure
REQ-032 The shared package uart_pkg SHALL hold the TX/RX state enums and the default CLKS_PER_BIT constant.
REQ-033 uart_transceiver SHALL instantiate the two sub-modules uart_tx and uart_rx, each carrying CLKS_PER_BIT, with clock and reset routed to both.

Verification
REQ-034 Loopback test: send 3F, A0, C1, 55, 00, FF, 1C, E3, 42, 7A -> one o_RX_DV per byte with o_RX_Byte equal to the sent byte, and o_TX_Done exactly 10*CLKS_PER_BIT+1 clocks after each i_TX_DV.
REQ-035 Direct RX test: drive 37, A5, C3, 7E, 00, FF, 81, 42, 19, E7 at 8680 ns per bit with 40 ns clocks -> each byte received correctly, and back-to-back frames are not lost.
REQ-036 Glitch test: a low pulse on i_RX_Serial of CLKS_PER_BIT/4 clocks -> no o_RX_DV, and o_RX_Byte unchanged.
REQ-037 Framing test: a frame for A5 with stop bit 0 -> no o_RX_DV, o_RX_Byte keeps its old value, and the next valid frame is received.
REQ-038 Busy test: pulse i_TX_DV with 81 while 3C is transmitting -> only 3C appears on the line, and o_TX_Active stays high for 10*CLKS_PER_BIT clocks.
REQ-039 Reset test: assert i_Reset during data bit 4 of a TX frame and an RX frame -> o_TX_Serial=1 and o_TX_Active=0 immediately, no o_TX_Done or o_RX_DV pulse, and a normal frame works after reset is released.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: TX/RX state encodings and the default bit period.
package uart_pkg;

  // 25 MHz clock / 115200 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_CLEANUP
  } rx_state_e;

endpackage

// File: rtl/uart_transceiver_if.sv
// Byte-level transmit/receive signal bundle between the user side and the UART.
interface uart_transceiver_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_serial;
  logic       tx_done;
  logic       rx_serial;
  logic       rx_dv;
  logic [7:0] rx_byte;

  modport master (
    output tx_dv, tx_byte, rx_serial,
    input  tx_active, tx_serial, tx_done, rx_dv, rx_byte
  );

  modport slave (
    input  tx_dv, tx_byte, rx_serial,
    output tx_active, tx_serial, tx_done, rx_dv, rx_byte
  );

  modport tx_slave (
    input  tx_dv, tx_byte,
    output tx_active, tx_serial, tx_done
  );

  modport rx_slave (
    input  rx_serial,
    output rx_dv, rx_byte
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop input synchronizer and mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_transceiver_if.rx_slave  bus
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q, byte_d;
  logic          dv_q, dv_d;
  logic          rx_bit;

  assign sync_d = {sync_q[0], bus.rx_serial};
  assign rx_bit = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_bit) state_d = RX_START;
      end
      // A start bit that is high again at its midpoint is treated as a glitch
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_bit ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_bit;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = RX_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_bit) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = RX_CLEANUP;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_CLEANUP: state_d = RX_IDLE;
      default:    state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
    end
  end

  assign bus.rx_dv   = dv_q;
  assign bus.rx_byte = byte_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; byte is latched on i_TX_DV in IDLE and shifted out LSB first.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_transceiver_if.tx_slave  bus
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    data_d   = data_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        cnt_d    = '0;
        bit_d    = '0;
        if (bus.tx_dv) begin
          data_d   = bus.tx_byte;
          serial_d = 1'b0;
          active_d = 1'b1;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          serial_d = data_q[0];
          state_d  = TX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // data_q is consumed by shifting; bit 0 is always the bit on the line
      TX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          data_d = {1'b0, data_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d    = '0;
            serial_d = 1'b1;
            state_d  = TX_STOP;
          end else begin
            bit_d    = bit_q + 3'd1;
            serial_d = data_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = TX_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_DONE: state_d = TX_IDLE;
      default: begin
        state_d  = TX_IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign bus.tx_serial = serial_q;
  assign bus.tx_active = active_q;
  assign bus.tx_done   = done_q;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock and reset.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte
);

  uart_transceiver_if bus ();

  assign bus.tx_dv     = i_TX_DV;
  assign bus.tx_byte   = i_TX_Byte;
  assign bus.rx_serial = i_RX_Serial;
  assign o_TX_Active   = bus.tx_active;
  assign o_TX_Serial   = bus.tx_serial;
  assign o_TX_Done     = bus.tx_done;
  assign o_RX_DV       = bus.rx_dv;
  assign o_RX_Byte     = bus.rx_byte;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk (i_Clock),
    .rst (i_Reset),
    .bus (bus)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk (i_Clock),
    .rst (i_Reset),
    .bus (bus)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Scoreboard bench for uart_transceiver: loopback, direct RX, glitch, framing, busy and reset cases.
module tb_uart_transceiver;

  localparam int unsigned CPB       = 217;
  localparam int unsigned BIT_T     = 8680;
  localparam int unsigned FRAME_CYC = 10 * CPB;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst;
  logic loopback;
  logic rx_drv;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  chk_t       chk_q[$];
  logic [7:0] exp_rx[$];
  int         exp_done[$];
  logic [7:0] ref_last;

  uart_transceiver_if u_bus ();

  assign u_bus.rx_serial = loopback ? u_bus.tx_serial : rx_drv;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_TX_DV     (u_bus.tx_dv),
    .i_TX_Byte   (u_bus.tx_byte),
    .o_TX_Active (u_bus.tx_active),
    .o_TX_Serial (u_bus.tx_serial),
    .o_TX_Done   (u_bus.tx_done),
    .i_RX_Serial (u_bus.rx_serial),
    .o_RX_DV     (u_bus.rx_dv),
    .o_RX_Byte   (u_bus.rx_byte)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_eq(input string name, input int act, input int exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endfunction

  // Monitor: the only process that steps total/bad
  always @(negedge clk) begin : monitor
    chk_t       c;
    logic [7:0] e;
    int         t0;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      total++;
      if (c.act != c.exp) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", c.name, c.act, c.exp);
      end
    end
    if (u_bus.rx_dv) begin
      total++;
      if (exp_rx.size() == 0) begin
        bad++;
        $display("FAIL rx_dv: unexpected pulse with byte %02h, want no pulse", u_bus.rx_byte);
      end else begin
        e = exp_rx.pop_front();
        if (u_bus.rx_byte !== e) begin
          bad++;
          $display("FAIL rx_byte: got %02h want %02h", u_bus.rx_byte, e);
        end
      end
    end
    if (u_bus.tx_done) begin
      total++;
      if (exp_done.size() == 0) begin
        bad++;
        $display("FAIL tx_done: unexpected pulse at cycle %0d, want no pulse", cyc);
      end else begin
        t0 = exp_done.pop_front();
        if (cyc - t0 != int'(FRAME_CYC + 1)) begin
          bad++;
          $display("FAIL tx_done_latency: got %0d want %0d", cyc - t0, FRAME_CYC + 1);
        end
      end
    end
  end

  task automatic send_tx(input logic [7:0] b, input bit want_done);
    @(posedge clk); #1;
    u_bus.tx_dv   = 1'b1;
    u_bus.tx_byte = b;
    if (want_done) exp_done.push_back(cyc);
    @(posedge clk); #1;
    u_bus.tx_dv   = 1'b0;
    u_bus.tx_byte = 8'($urandom);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    #(BIT_T);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      #(BIT_T);
    end
    rx_drv = stop;
    #(BIT_T);
    rx_drv = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  logic [7:0] lb_bytes[10] = '{8'h3F, 8'hA0, 8'hC1, 8'h55, 8'h00, 8'hFF, 8'h1C, 8'hE3, 8'h42, 8'h7A};
  logic [7:0] rx_bytes[10] = '{8'h37, 8'hA5, 8'hC3, 8'h7E, 8'h00, 8'hFF, 8'h81, 8'h42, 8'h19, 8'hE7};

  initial begin
    logic [7:0] b, b2;
    int         act_cnt;
    rst           = 1'b1;
    loopback      = 1'b1;
    rx_drv        = 1'b1;
    u_bus.tx_dv   = 1'b0;
    u_bus.tx_byte = 8'h00;
    ref_last      = 8'h00;

    repeat (5) @(posedge clk); #1;
    expect_eq("reset_tx_serial", int'(u_bus.tx_serial), 1);
    expect_eq("reset_tx_active", int'(u_bus.tx_active), 0);
    expect_eq("reset_tx_done",   int'(u_bus.tx_done),   0);
    expect_eq("reset_rx_dv",     int'(u_bus.rx_dv),     0);
    expect_eq("reset_rx_byte",   int'(u_bus.rx_byte),   0);
    rst = 1'b0;
    idle_cycles(10);

    // Loopback: fixed list then a few random bytes, random idle gaps
    for (int i = 0; i < 13; i++) begin
      b = (i < 10) ? lb_bytes[i] : 8'($urandom);
      exp_rx.push_back(b);
      ref_last = b;
      send_tx(b, 1'b1);
      idle_cycles(int'(FRAME_CYC) + int'($urandom_range(5, 40)));
    end
    expect_eq("loopback_rx_byte_hold", int'(u_bus.rx_byte), int'(ref_last));

    // Direct RX, back-to-back frames, with an independent TX frame in flight
    loopback = 1'b0;
    fork
      send_tx(8'($urandom), 1'b1);
    join_none
    for (int i = 0; i < 10; i++) begin
      exp_rx.push_back(rx_bytes[i]);
      drive_rx_frame(rx_bytes[i], 1'b1);
      ref_last = rx_bytes[i];
    end
    idle_cycles(2 * CPB);
    expect_eq("direct_rx_byte_hold", int'(u_bus.rx_byte), int'(ref_last));

    // Glitch shorter than half a bit
    @(posedge clk); #1;
    rx_drv = 1'b0;
    idle_cycles(CPB / 4);
    #1 rx_drv = 1'b1;
    idle_cycles(3 * CPB);
    expect_eq("glitch_rx_byte", int'(u_bus.rx_byte), int'(ref_last));

    // Framing error, then a good frame
    drive_rx_frame(8'hA5, 1'b0);
    idle_cycles(2 * CPB);
    expect_eq("framing_rx_byte", int'(u_bus.rx_byte), int'(ref_last));
    b = 8'($urandom);
    exp_rx.push_back(b);
    drive_rx_frame(b, 1'b1);
    idle_cycles(CPB);
    ref_last = b;
    expect_eq("post_framing_rx_byte", int'(u_bus.rx_byte), int'(ref_last));

    // Busy: second request mid-frame must be ignored
    loopback = 1'b1;
    @(posedge clk); #1;
    u_bus.tx_dv   = 1'b1;
    u_bus.tx_byte = 8'h3C;
    exp_done.push_back(cyc);
    exp_rx.push_back(8'h3C);
    act_cnt = 0;
    for (int i = 0; i < int'(FRAME_CYC) + 40; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        u_bus.tx_dv   = 1'b0;
        u_bus.tx_byte = 8'h81;
      end
      if (i == 500) u_bus.tx_dv = 1'b1;
      if (i == 501) u_bus.tx_dv = 1'b0;
      @(negedge clk);
      if (u_bus.tx_active) act_cnt++;
    end
    expect_eq("busy_active_cycles", act_cnt, int'(FRAME_CYC));
    ref_last = 8'h3C;
    idle_cycles(int'(FRAME_CYC) + 50);
    expect_eq("busy_rx_byte", int'(u_bus.rx_byte), int'(ref_last));

    // Reset during data bit 4 of simultaneous TX and RX frames
    loopback = 1'b0;
    b  = 8'($urandom);
    b2 = 8'($urandom);
    fork
      send_tx(b, 1'b0);
      drive_rx_frame(b2, 1'b1);
      begin
        idle_cycles(5 * CPB + 100);
        #1 rst = 1'b1;
        #1;
        expect_eq("abort_tx_serial", int'(u_bus.tx_serial), 1);
        expect_eq("abort_tx_active", int'(u_bus.tx_active), 0);
      end
    join
    idle_cycles(3); #1;
    ref_last = 8'h00;
    expect_eq("abort_rx_byte", int'(u_bus.rx_byte), int'(ref_last));
    expect_eq("abort_tx_done", int'(u_bus.tx_done), 0);
    rst = 1'b0;
    idle_cycles(10);
    loopback = 1'b1;
    b = 8'($urandom);
    exp_rx.push_back(b);
    send_tx(b, 1'b1);
    idle_cycles(int'(FRAME_CYC) + 20);
    ref_last = b;
    expect_eq("post_reset_rx_byte", int'(u_bus.rx_byte), int'(ref_last));

    expect_eq("rx_outstanding",   exp_rx.size(),   0);
    expect_eq("done_outstanding", exp_done.size(), 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
